// File: rtl/cpu_debug_display.sv
// Board-side debug controller for the single-cycle core: generates the core clock
// enable (free run or debounced single step) and scans a multi-digit 7-segment display.
module cpu_debug_display #(
    parameter int STEP_DIV        = 100_000_000,
    parameter int SCAN_DIV        = 100_000,
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode_run,
    input  logic                    step_btn,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic                    cpu_ce,
    output logic [7:0]              an,
    output logic [7:0]              seg,
    output logic [15:0]             step_count
);

    localparam int DIV_W  = $clog2(STEP_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(STEP_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]        DIG_MAX  = 3'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic mode_s1, mode_s2, btn_s1, btn_s2;
    logic [DIV_W-1:0] div;
    logic [DB_W-1:0] db_cnt;
    logic deb, deb_prev, armed;
    logic mode_edge, run_tick, step_tick;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0] digit;
    logic [3:0] nib_p0;
    logic dp_p0, zero_up, blank_p0;
    logic [7:0] an_p0;

    // Synchronizers carry no reset so they already track the pins at reset release;
    // this keeps a held button from looking like a fresh press.
    always_ff @(posedge clk) begin
        mode_s1 <= mode_run;
        mode_s2 <= mode_s1;
        btn_s1  <= step_btn;
        btn_s2  <= btn_s1;
    end

    // A mode flip is seen one cycle before the synchronized level changes, so the
    // divider is already 0 on the first cycle of the new mode.
    assign mode_edge = mode_s1 ^ mode_s2;
    assign run_tick  = mode_s2 && !mode_edge && (div == DIV_MAX);
    assign step_tick = !mode_s2 && armed && deb && !deb_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (mode_edge || !mode_s2 || div == DIV_MAX)
            div <= '0;
        else
            div <= div + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            deb      <= 1'b0;
            deb_prev <= 1'b0;
            armed    <= 1'b0;
        end else begin
            deb_prev <= deb;
            armed    <= armed | ~btn_s2;
            if (btn_s2 == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                deb    <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ce      <= 1'b0;
            step_count  <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else begin
            cpu_ce     <= run_tick | step_tick;
            step_count <= step_count + 16'(cpu_ce);
            if (cpu_ce) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            digit    <= (digit == DIG_MAX) ? 3'd0 : digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Stage p0: select the active digit's nibble, point and blanking state
    always_comb begin
        nib_p0  = 4'h0;
        dp_p0   = 1'b0;
        zero_up = 1'b1;
        an_p0   = 8'hFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit == 3'(i)) begin
                nib_p0 = shadow_data[4*i +: 4];
                dp_p0  = shadow_dp[i];
            end
            if (3'(i) >= digit && shadow_data[4*i +: 4] != 4'h0)
                zero_up = 1'b0;
        end
        blank_p0     = blank_lz && (digit != 3'd0) && zero_up;
        an_p0[digit] = 1'b0;
    end

    // Stage p1: registered anode and segment drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= an_p0;
            seg <= blank_p0 ? 8'hFF : {~dp_p0, hex7(nib_p0)};
        end
    end

endmodule

// File: tb/tb_cpu_debug_display.sv
// Directed bench for cpu_debug_display with small dividers so every path is reached quickly.
module tb_cpu_debug_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_run;
    logic        step_btn;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        cpu_ce;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;

    cpu_debug_display #(
        .STEP_DIV(4), .SCAN_DIV(2), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .mode_run(mode_run), .step_btn(step_btn),
        .data_in(data_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .cpu_ce(cpu_ce), .an(an), .seg(seg), .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_step();
        step_btn = 1'b1;
        repeat (8) tick();
        step_btn = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_run = 1'b1; step_btn = 1'b0;
        data_in = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
        repeat (3) tick();
        checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", cpu_ce); end
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h want ff", an); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg); end
        checks++; if (step_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0", step_count); end
        rst = 1'b0;
    endtask

    task automatic test_run_mode();
        logic exp;
        for (int n = 1; n <= 13; n++) begin
            tick();
            exp = (n % 4 == 0);
            checks++;
            if (cpu_ce !== exp) begin errors++; $display("FAIL run_ce cycle %0d: got %b want %b", n, cpu_ce, exp); end
            if (n == 1) begin
                checks++;
                if (an !== 8'hFE || seg !== 8'hC0) begin
                    errors++; $display("FAIL first_drive: got an=%h seg=%h want fe c0", an, seg);
                end
            end
        end
        checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL run_count: got %0d want 3", step_count); end
    endtask

    task automatic test_switch_to_step();
        tick();
        mode_run = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (cpu_ce !== 1'b0) begin errors++; $display("FAIL switch_step_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL switch_step_count: got %0d want 3", step_count); end
    endtask

    task automatic test_step_press();
        logic exp;
        data_in = 16'h0A05; dp_in = 4'b0001; blank_lz = 1'b0;
        step_btn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = (k == 6);
            checks++;
            if (cpu_ce !== exp) begin errors++; $display("FAIL step_ce k=%0d: got %b want %b", k, cpu_ce, exp); end
            if (k == 20) step_btn = 1'b0;
        end
        checks++; if (step_count !== 16'd4) begin errors++; $display("FAIL step_count: got %0d want 4", step_count); end
    endtask

    task automatic test_glitch();
        step_btn = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 2) step_btn = 1'b0;
            checks++;
            if (cpu_ce !== 1'b0) begin errors++; $display("FAIL glitch_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        checks++; if (step_count !== 16'd4) begin errors++; $display("FAIL glitch_count: got %0d want 4", step_count); end
    endtask

    task automatic test_display();
        logic [7:0] exp_seg [4];
        exp_seg[0] = 8'h12; exp_seg[1] = 8'hC0; exp_seg[2] = 8'h88; exp_seg[3] = 8'hC0;
        for (int d = 0; d < 4; d++) begin
            logic [7:0] exp_an;
            int waited;
            exp_an = 8'hFF; exp_an[d] = 1'b0;
            waited = 0;
            while (an !== exp_an && waited < 20) begin tick(); waited++; end
            checks++;
            if (an !== exp_an) begin
                errors++; $display("FAIL display_an%0d: got %h want %h", d, an, exp_an);
            end else if (seg !== exp_seg[d]) begin
                errors++; $display("FAIL display_seg%0d: got %h want %h", d, seg, exp_seg[d]);
            end
        end
    endtask

    task automatic test_blank();
        logic [15:0] pat [2];
        logic [7:0]  exp_seg [2][4];
        pat[0] = 16'h0005;
        exp_seg[0][0] = 8'h92; exp_seg[0][1] = 8'hFF; exp_seg[0][2] = 8'hFF; exp_seg[0][3] = 8'hFF;
        pat[1] = 16'h0500;
        exp_seg[1][0] = 8'hC0; exp_seg[1][1] = 8'hC0; exp_seg[1][2] = 8'h92; exp_seg[1][3] = 8'hFF;
        dp_in = 4'h0; blank_lz = 1'b1;
        for (int p = 0; p < 2; p++) begin
            data_in = pat[p];
            press_step();
            for (int d = 0; d < 4; d++) begin
                logic [7:0] exp_an;
                int waited;
                exp_an = 8'hFF; exp_an[d] = 1'b0;
                waited = 0;
                while (an !== exp_an && waited < 20) begin tick(); waited++; end
                checks++;
                if (an !== exp_an) begin
                    errors++; $display("FAIL blank_an p%0d d%0d: got %h want %h", p, d, an, exp_an);
                end else if (seg !== exp_seg[p][d]) begin
                    errors++; $display("FAIL blank_seg p%0d d%0d: got %h want %h", p, d, seg, exp_seg[p][d]);
                end
            end
        end
        checks++; if (step_count !== 16'd6) begin errors++; $display("FAIL blank_count: got %0d want 6", step_count); end
    endtask

    task automatic test_switch_to_run();
        logic exp;
        mode_run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = (k == 6) || (k == 10);
            checks++;
            if (cpu_ce !== exp) begin errors++; $display("FAIL switch_run_ce k=%0d: got %b want %b", k, cpu_ce, exp); end
        end
    endtask

    task automatic test_count_wrap();
        mode_run = 1'b0;
        repeat (6) tick();
        force dut.step_count = 16'hFFFF;
        #1;
        release dut.step_count;
        tick();
        checks++; if (step_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", step_count); end
        press_step();
        checks++; if (step_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", step_count); end
    endtask

    task automatic test_reset_mid();
        logic exp;
        mode_run = 1'b1;
        repeat (7) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL midrst_an: got %h want ff", an); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL midrst_seg: got %h want ff", seg); end
        checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL midrst_ce: got %b want 0", cpu_ce); end
        checks++; if (step_count !== 16'h0) begin errors++; $display("FAIL midrst_count: got %h want 0", step_count); end
        mode_run = 1'b0;
        step_btn = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (cpu_ce !== 1'b0) begin errors++; $display("FAIL held_btn_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        step_btn = 1'b0;
        repeat (10) tick();
        step_btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 6);
            checks++;
            if (cpu_ce !== exp) begin errors++; $display("FAIL repress_ce k=%0d: got %b want %b", k, cpu_ce, exp); end
        end
        step_btn = 1'b0;
        tick();
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL repress_count: got %0d want 1", step_count); end
    endtask

    initial begin
        test_reset();
        test_run_mode();
        test_switch_to_step();
        test_step_press();
        test_glitch();
        test_display();
        test_blank();
        test_switch_to_run();
        test_count_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_debug_display.md
# cpu_debug_display

Board-level debug controller that sits between the board clock and the RV32I single-cycle core. It generates the core's clock enable, either free-running at a divided rate or one pulse per debounced push-button press. It also drives a time-multiplexed, parametrised multi-digit 7-segment display of a data word latched after every core step. It replaces the fixed single-digit display and toggled slow clock with a single-clock-domain, clock-enable design.

## Interface
- STEP_DIV, 100_000_000: board cycles between `cpu_ce` pulses in run mode (≥2).
- SCAN_DIV, 100_000: board cycles each digit stays active (≥1).
- NUM_DIGITS, 8: digits displayed, 1..8.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples needed to accept a button level (≥1).
- clk  in  1  board clock.
- rst  in  1  reset, asynchronous, active-high.
- mode_run  in  1  async; 1 = free run, 0 = single step.
- step_btn  in  1  async raw push button, active-high.
- data_in  in  4*NUM_DIGITS  value to display; nibble i drives digit i (digit 0 rightmost).
- dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit.
- blank_lz  in  1  1 = blank leading zero digits.
- cpu_ce  out  1  one-cycle core clock enable.
- an  out  8  digit anodes, active-low.
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- step_count  out  16  number of `cpu_ce` pulses since reset.

## Operation
- Reset values: `cpu_ce`=0, `an`=8'hFF, `seg`=8'hFF, `step_count`=0. The shadow register, all counters, and the digit index are 0. The debounced button level is 0.
- `mode_run` and `step_btn` each pass through a 2-FF synchronizer.
- Run mode: a divider counts 0..STEP_DIV-1. `cpu_ce`=1 for the single cycle in which the counter equals STEP_DIV-1, and the counter wraps to 0 on that same cycle.
- Step mode: the divider is held at 0. A debounce counter tracks the synchronized button. The debounced level updates only after DEBOUNCE_CYCLES consecutive samples that differ from it. A 0→1 transition of the debounced level produces exactly one `cpu_ce` pulse. Holding or releasing the button produces nothing further.
- The debouncer runs in both modes. Button edges while in run mode never pulse `cpu_ce`.
- A change of synchronized `mode_run` clears the divider to 0. No pulse is issued on the switch cycle.
- `step_count` increments by 1 on every `cpu_ce` and wraps from 16'hFFFF to 0.
- Shadow latch: on the cycle after each `cpu_ce`, `data_in`/`dp_in` are copied into the shadow register. The display shows only shadow contents.
- Scan: the digit index advances every SCAN_DIV cycles and wraps from NUM_DIGITS-1 to 0. `an` bits ≥ NUM_DIGITS are always 1.
- Decode (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - `seg[7]` = ~dp of the active digit.
- Leading-zero blank: digit i (i≥1) is blanked when `blank_lz`=1 and shadow nibbles i..NUM_DIGITS-1 are all 0. A blanked digit still has its anode asserted but drives `seg`=8'hFF, including dp. Digit 0 is never blanked.

## Timing
- `an`/`seg` are registered and change 1 cycle after the digit index changes. The first valid drive after reset release is digit 0 in cycle 1.
- Run mode: the first `cpu_ce` occurs STEP_DIV cycles after reset release (or after a mode switch), then every STEP_DIV cycles.
- Step mode: from a clean `step_btn` rise, `cpu_ce` rises 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later.
- The shadow register updates 1 cycle after `cpu_ce`. The new value appears on the display at the next digit-index change.
- A glitch shorter than DEBOUNCE_CYCLES restarts the debounce count and produces no pulse.
- Reset asserted mid-count or mid-press immediately forces all reset values. A button held through reset release does not pulse until it is released and pressed again.

## Test plan
Test parameters: STEP_DIV=4, SCAN_DIV=2, NUM_DIGITS=4, DEBOUNCE_CYCLES=3.
- Run mode, reset released at cycle 0 → `cpu_ce` pulses at cycles 4, 8, 12. `step_count`=3 after cycle 12.
- Step mode: press held for 20 cycles → exactly one pulse, 6 cycles after the rise. A 2-cycle glitch → no pulse.
- `data_in`=16'h0A05, `dp_in`=4'b0001, `blank_lz`=0, followed by a step → `an` cycles through E,D,B,7 with `seg` values 8'h12 (5 with dp), 8'hC0 (0), 8'h88 (A), 8'hC0 (0).
- `data_in`=16'h0005, `blank_lz`=1 → digits 1–3 drive `seg`=8'hFF and digit 0 drives 8'h92.
- Switch run→step mid-count → no `cpu_ce` until the next press. Switch back to run → first pulse 4 cycles after the synchronized change.
- Force `step_count` to 16'hFFFF, then one step → `step_count`=0. Assert `rst` mid-scan → `an`=8'hFF and `seg`=8'hFF immediately.
